// File: rtl/updown_ctrl_pkg.sv
// Shared definitions for the up/down command controller: FSM states, direction codes,
// default sizing constants and a small elaboration helper.
package updown_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        FIRE,
        HOLD,
        WAIT_REL
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int DEF_WIDTH         = 16;
    localparam int DEF_DB_CYCLES     = 2;
    localparam int DEF_REPEAT_DELAY  = 50;
    localparam int DEF_REPEAT_PERIOD = 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for one asynchronous button input; cleared by the
// synchronous active-high reset.
module btn_sync (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic sync
);

    logic meta;

    // NOTE: non-blocking assignments make both flops sample on the same edge, which is what forms a real two-stage chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

endmodule

// File: rtl/updown_ctrl_fsm.sv
// Turns raw u/d buttons into single-cycle inc/dec commands for the up/down counter,
// refusing commands that would wrap. Define UPDOWN_CTRL_REPEAT_EN for auto-repeat on hold.
module updown_ctrl_fsm
    import updown_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DB_CYCLES = DEF_DB_CYCLES
`ifdef UPDOWN_CTRL_REPEAT_EN
   ,parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             u,
    input  logic             d,
    input  logic [WIDTH-1:0] count,
    output logic             inc,
    output logic             dec,
    output logic             blocked,
    output logic             conflict,
    output logic             busy
);

    localparam int              DB_W    = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            u_s;
    logic            d_s;
    state_e          state;
    dir_e            dir;
    logic [DB_W-1:0] db_cnt;

    btn_sync u_sync (.clk(clk), .reset(reset), .raw(u), .sync(u_s));
    btn_sync d_sync (.clk(clk), .reset(reset), .raw(d), .sync(d_s));

    // held/other are relative to the direction latched when the press was first seen.
    logic held;
    logic other;
    logic at_limit;
    logic fire_inc;
    logic fire_dec;

    assign held     = (dir == DIR_UP) ? u_s : d_s;
    assign other    = (dir == DIR_UP) ? d_s : u_s;
    assign at_limit = (dir == DIR_UP) ? (count == '1) : (count == '0);
    assign fire_inc = (dir == DIR_UP)   && !at_limit;
    assign fire_dec = (dir == DIR_DOWN) && !at_limit;

`ifdef UPDOWN_CTRL_REPEAT_EN
    localparam int               RPT_W     = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             repeating;
    logic             rpt_due;

    assign rpt_due = (rpt_cnt == (repeating ? RPT_NEXT : RPT_FIRST));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dir       <= DIR_UP;
            db_cnt    <= '0;
            inc       <= 1'b0;
            dec       <= 1'b0;
            blocked   <= 1'b0;
            conflict  <= 1'b0;
            busy      <= 1'b0;
`ifdef UPDOWN_CTRL_REPEAT_EN
            rpt_cnt   <= '0;
            repeating <= 1'b0;
`endif
        end else begin
            // Pulses fall back low every cycle; busy is set here and cleared on every path into IDLE.
            inc      <= 1'b0;
            dec      <= 1'b0;
            blocked  <= 1'b0;
            conflict <= 1'b0;
            busy     <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (u_s && d_s) begin
                        state    <= WAIT_REL;
                        conflict <= 1'b1;
                    end else if (u_s || d_s) begin
                        dir    <= u_s ? DIR_UP : DIR_DOWN;
                        db_cnt <= '0;
                        state  <= DEBOUNCE;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                DEBOUNCE: begin
                    if (other) begin
                        state    <= WAIT_REL;
                        conflict <= 1'b1;
                    end else if (!held) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (db_cnt == DB_LAST) begin
                        state   <= FIRE;
                        inc     <= fire_inc;
                        dec     <= fire_dec;
                        blocked <= at_limit;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end

                FIRE: begin
                    state <= HOLD;
`ifdef UPDOWN_CTRL_REPEAT_EN
                    rpt_cnt <= '0;
`endif
                end

                HOLD: begin
                    if (!u_s && !d_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
`ifdef UPDOWN_CTRL_REPEAT_EN
                        rpt_cnt   <= '0;
                        repeating <= 1'b0;
                    end else if (!held) begin
                        rpt_cnt <= '0;
                    end else if (rpt_due) begin
                        state     <= FIRE;
                        inc       <= fire_inc;
                        dec       <= fire_dec;
                        blocked   <= at_limit;
                        repeating <= 1'b1;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
`endif
                    end
                end

                WAIT_REL: begin
                    if (!u_s && !d_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_updown_ctrl_fsm.sv
// Directed bench for updown_ctrl_fsm: a press-timing model predicts every output per cycle,
// and the bench itself plays the role of the counter fed by inc/dec.
`timescale 1ns/1ps
module tb_updown_ctrl_fsm;

    localparam int WIDTH = 16;
    localparam int DB    = 2;
    localparam int RD    = 5;
    localparam int RP    = 3;
`ifdef UPDOWN_CTRL_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif
    localparam int               MAXC = 1024;
    localparam logic [WIDTH-1:0] MAXV = '1;

    logic             clk = 1'b0;
    logic             reset;
    logic             u;
    logic             d;
    logic [WIDTH-1:0] count;
    logic             inc;
    logic             dec;
    logic             blocked;
    logic             conflict;
    logic             busy;

    updown_ctrl_fsm #(
        .WIDTH(WIDTH),
        .DB_CYCLES(DB)
`ifdef UPDOWN_CTRL_REPEAT_EN
       ,.REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .u(u),
        .d(d),
        .count(count),
        .inc(inc),
        .dec(dec),
        .blocked(blocked),
        .conflict(conflict),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // cyc == e after rising edge e; outputs of that cycle are sampled on the following falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // The counter that the controller drives.
    logic [WIDTH-1:0] cnt_q;
    logic             preset_en  = 1'b1;
    logic [WIDTH-1:0] preset_val = '0;
    always @(posedge clk) begin
        if (preset_en)  cnt_q <= preset_val;
        else if (inc)   cnt_q <= cnt_q + 1'b1;
        else if (dec)   cnt_q <= cnt_q - 1'b1;
    end
    assign count = cnt_q;

    // Model: expected value of every output for every cycle.
    bit               exp_inc [MAXC];
    bit               exp_dec [MAXC];
    bit               exp_blk [MAXC];
    bit               exp_cfl [MAXC];
    bit               exp_busy[MAXC];
    logic [WIDTH-1:0] mdl_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int inc_q[$];
    int blk_n = 0;
    int cfl_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic fire_at(input bit up, input int c);
        if (c >= MAXC) return;
        if (up) begin
            if (mdl_cnt == MAXV) exp_blk[c] = 1'b1;
            else begin exp_inc[c] = 1'b1; mdl_cnt = mdl_cnt + 1'b1; end
        end else begin
            if (mdl_cnt == '0) exp_blk[c] = 1'b1;
            else begin exp_dec[c] = 1'b1; mdl_cnt = mdl_cnt - 1'b1; end
        end
    endtask

    task automatic plan_busy(input int a, input int b);
        for (int i = a; i <= b; i++) if (i < MAXC) exp_busy[i] = 1'b1;
    endtask

    // Raw button high at edges n..n+len-1 reaches the FSM at edges n+2..n+len+1.
    // Accepted after DB+1 such edges; command in the cycle after edge n+2+DB.
    task automatic plan_press(input bit up, input int n, input int len);
        int rel;
        int last;
        int nxt;
        rel  = n + len + 1;
        last = n + 1;
        if (len >= DB + 1) begin
            last = n + 2 + DB;
            fire_at(up, last);
            if (REP) begin
                nxt = last + RD + 1;
                while (nxt <= rel) begin
                    fire_at(up, nxt);
                    last = nxt;
                    nxt  = nxt + RP + 1;
                end
            end
        end
        plan_busy(n + 2, (rel > last + 1) ? rel : last + 1);
    endtask

    task automatic plan_conflict(input int n, input int len);
        if (n + 2 < MAXC) exp_cfl[n + 2] = 1'b1;
        plan_busy(n + 2, n + len + 1);
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            check("inc",      inc,      exp_inc[cyc]);
            check("dec",      dec,      exp_dec[cyc]);
            check("blocked",  blocked,  exp_blk[cyc]);
            check("conflict", conflict, exp_cfl[cyc]);
            check("busy",     busy,     exp_busy[cyc]);
            if (inc === 1'b1)      inc_q.push_back(cyc);
            if (blocked === 1'b1)  blk_n++;
            if (conflict === 1'b1) cfl_n++;
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic set_count(input logic [WIDTH-1:0] v);
        preset_val = v;
        preset_en  = 1'b1;
        tick(1);
        preset_en  = 1'b0;
        mdl_cnt    = v;
    endtask

    task automatic press(input bit pu, input bit pd, input int len, output int n);
        n = cyc + 1;
        if (pu && pd) plan_conflict(n, len);
        else          plan_press(pu, n, len);
        u = pu;
        d = pd;
        tick(len);
        u = 1'b0;
        d = 1'b0;
        tick(12);
    endtask

    initial begin
        int n;
        int offs[5];
        offs = '{0, 6, 10, 14, 18};

        reset   = 1'b1;
        u       = 1'b0;
        d       = 1'b0;
        mdl_cnt = '0;
        tick(3);
        reset     = 1'b0;
        preset_en = 1'b0;
        check("reset_inc",      inc,      1'b0);
        check("reset_dec",      dec,      1'b0);
        check("reset_blocked",  blocked,  1'b0);
        check("reset_conflict", conflict, 1'b0);
        check("reset_busy",     busy,     1'b0);
        chk_en = 1'b1;

        // Clean up-press from 0: one inc, four cycles after u is first sampled.
        inc_q.delete();
        press(1'b1, 1'b0, 3, n);
        check("up_inc_pulses", inc_q.size(), 1);
        if (inc_q.size() > 0) check("up_inc_latency", inc_q[0] - n, 4);
        check("up_count", cnt_q, 1);

        // One-cycle glitch on d: no command.
        inc_q.delete();
        press(1'b0, 1'b1, 1, n);
        check("glitch_count", cnt_q, 1);
        check("glitch_inc_pulses", inc_q.size(), 0);

        // Down at 0 and up at max are refused.
        set_count('0);
        blk_n = 0;
        press(1'b0, 1'b1, 3, n);
        check("down_at_zero_blocked", blk_n, 1);
        check("down_at_zero_count", cnt_q, 0);
        set_count(MAXV);
        press(1'b1, 1'b0, 3, n);
        check("up_at_max_blocked", blk_n, 2);
        check("up_at_max_count", cnt_q, 32'hFFFF);

        // Down from max is allowed.
        press(1'b0, 1'b1, 4, n);
        check("down_from_max_count", cnt_q, 32'hFFFE);

        // Both buttons together.
        cfl_n = 0;
        press(1'b1, 1'b1, 3, n);
        check("conflict_pulses", cfl_n, 1);
        check("conflict_count", cnt_q, 32'hFFFE);

        // Reset during DEBOUNCE with u still held: one inc after re-synchronise and re-debounce.
        set_count(16'd10);
        inc_q.delete();
        n = cyc + 1;
        plan_busy(n + 2, n + 2);
        u = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        plan_press(1'b1, n + 5, 5);
        tick(5);
        u = 1'b0;
        tick(12);
        check("reset_mid_inc_pulses", inc_q.size(), 1);
        if (inc_q.size() > 0) check("reset_mid_inc_latency", inc_q[0] - n, 9);
        check("reset_mid_count", cnt_q, 11);

        // Long hold: a single command, or auto-repeat when enabled.
        set_count('0);
        inc_q.delete();
        press(1'b1, 1'b0, 21, n);
`ifdef UPDOWN_CTRL_REPEAT_EN
        check("hold_inc_pulses", inc_q.size(), 5);
        check("hold_count", cnt_q, 5);
        for (int i = 0; i < 5; i++)
            if (i < inc_q.size()) check("hold_inc_offset", inc_q[i] - inc_q[0], offs[i]);
`else
        check("hold_inc_pulses", inc_q.size(), 1);
        check("hold_count", cnt_q, 1);
        if (inc_q.size() > 0) check("hold_inc_latency", inc_q[0] - n, offs[0] + 4);
`endif

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
